// File: rtl/md_pkg.sv
// Shared constants and types for the motion-update scheduler: cell geometry,
// particle word layout, the null-particle marker and the scheduler states.
package md_pkg;

    localparam int N_CELL     = 27;
    localparam int DEPTH      = 64;
    localparam int PARTICLE_W = 97;
    localparam int NULL_BIT   = 96;

    localparam logic [PARTICLE_W-1:0] NULL_PARTICLE = {1'b1, {(PARTICLE_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_CLOSE,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/cell_fill_counters.sv
// Per-destination-cell fill counters, saturating at DEPTH, with a single
// shared index used both for the increment and for the read-out.
module cell_fill_counters #(
    parameter int N_CELL = 27,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              inc,
    input  logic [4:0]        idx,
    output logic [ADDR_W:0]   cnt,
    output logic              full
);

    localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W+1)'(DEPTH);
    localparam logic [4:0]      CELL_LIMIT = 5'(N_CELL);

    logic [ADDR_W:0] cnt_arr [N_CELL];

    generate
        for (genvar gi = 0; gi < N_CELL; gi++) begin : g_cnt
            logic [ADDR_W:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (clear) begin
                    cnt_reg <= '0;
                end else if (inc && idx == 5'(gi) && cnt_reg != DEPTH_C) begin
                    cnt_reg <= cnt_reg + (ADDR_W+1)'(1);
                end
            end

            assign cnt_arr[gi] = cnt_reg;
        end
    endgenerate

    // Out-of-range indices read as an empty, non-full counter.
    always_comb begin
        cnt = '0;
        if (idx < CELL_LIMIT) begin
            cnt = cnt_arr[idx];
        end
    end

    assign full = (cnt == DEPTH_C);

endmodule

// File: rtl/motion_update_scheduler.sv
// Motion-update pass sequencer: streams source cells through the external
// cell-index datapath, bins results into destination cells, null-closes them.
module motion_update_scheduler #(
    parameter int N_CELL = md_pkg::N_CELL,
    parameter int DEPTH  = md_pkg::DEPTH,
    parameter int ADDR_W = 6,
    parameter int DP_LAT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic                          bank,
    output logic                          rd_en,
    output logic [4:0]                    rd_cell,
    output logic [ADDR_W-1:0]             rd_addr,
    input  logic [md_pkg::PARTICLE_W-1:0] rd_p,
    input  logic [md_pkg::PARTICLE_W-1:0] rd_v,
    output logic                          dp_valid,
    output logic [md_pkg::PARTICLE_W-1:0] dp_p,
    output logic [md_pkg::PARTICLE_W-1:0] dp_v,
    input  logic [32:0]                   dp_cidx,
    input  logic [md_pkg::PARTICLE_W-1:0] dp_newp,
    output logic                          wr_en,
    output logic [4:0]                    wr_cell,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [md_pkg::PARTICLE_W-1:0] wr_data
);
    import md_pkg::*;

    localparam logic [4:0]        LAST_CELL  = 5'(N_CELL - 1);
    localparam logic [4:0]        CELL_LIMIT = 5'(N_CELL);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam int                DRAIN_W    = $clog2(DP_LAT + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DP_LAT);

    sched_state_t        state_reg, state_next;
    logic [4:0]          cell_reg, cell_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DRAIN_W-1:0]  drain_reg, drain_next;
    logic                pend_real_reg, pend_real_next;
    logic                pend_full_reg, pend_full_next;
    logic                overflow_reg, bank_reg;
    logic [DP_LAT-1:0]   vsr_reg, vsr_next;

    logic                squash, accept_start;
    logic                res_valid, res_null, dst_bad, res_write, close_write, ovf_set;
    logic [4:0]          cnt_idx;
    logic [ADDR_W:0]     cnt_val;
    logic                cnt_full;
    logic                unused_cidx;

    assign unused_cidx  = ^dp_cidx[31:5];
    assign accept_start = (state_reg == ST_IDLE) && start;

    // A null returned from a non-final slot ends the cell: the read being
    // issued right now is speculative and must be discarded.
    assign squash   = pend_real_reg && rd_p[NULL_BIT] && !pend_full_reg;
    assign dp_valid = pend_real_reg && !rd_p[NULL_BIT];

    assign vsr_next[0] = dp_valid;
    generate
        for (genvar gi = 1; gi < DP_LAT; gi++) begin : g_vsr
            assign vsr_next[gi] = vsr_reg[gi-1];
        end
    endgenerate

    assign res_valid   = vsr_reg[DP_LAT-1];
    assign res_null    = dp_cidx[32];
    assign dst_bad     = dp_cidx[4:0] >= CELL_LIMIT;
    assign cnt_idx     = (state_reg == ST_CLOSE) ? cell_reg : dp_cidx[4:0];
    assign res_write   = res_valid && !res_null && !dst_bad && !cnt_full;
    assign ovf_set     = res_valid && !res_null && (dst_bad || cnt_full);
    assign close_write = (state_reg == ST_CLOSE) && !cnt_full;

    cell_fill_counters #(
        .N_CELL (N_CELL),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_counters (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept_start),
        .inc   (res_write),
        .idx   (cnt_idx),
        .cnt   (cnt_val),
        .full  (cnt_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cell_reg      <= '0;
            addr_reg      <= '0;
            drain_reg     <= '0;
            pend_real_reg <= 1'b0;
            pend_full_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            bank_reg      <= 1'b0;
            vsr_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            cell_reg      <= cell_next;
            addr_reg      <= addr_next;
            drain_reg     <= drain_next;
            pend_real_reg <= pend_real_next;
            pend_full_reg <= pend_full_next;
            vsr_reg       <= vsr_next;
            if (accept_start) begin
                overflow_reg <= 1'b0;
            end else if (ovf_set) begin
                overflow_reg <= 1'b1;
            end
            if (state_reg == ST_DONE) begin
                bank_reg <= ~bank_reg;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cell_next      = cell_reg;
        addr_next      = addr_reg;
        drain_next     = drain_reg;
        pend_real_next = (state_reg == ST_READ) && !squash;
        pend_full_next = (state_reg == ST_READ) && (addr_reg == LAST_ADDR);
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_READ;
                    cell_next  = '0;
                    addr_next  = '0;
                end
            end
            ST_READ: begin
                if (squash || addr_reg == LAST_ADDR) begin
                    addr_next = '0;
                    if (cell_reg == LAST_CELL) begin
                        state_next = ST_DRAIN;
                        drain_next = '0;
                    end else begin
                        cell_next = cell_reg + 5'd1;
                    end
                end else begin
                    addr_next = addr_reg + ADDR_W'(1);
                end
            end
            // Fixed length covers the final return plus a full pipe flush.
            ST_DRAIN: begin
                if (drain_reg == DRAIN_LAST) begin
                    state_next = ST_CLOSE;
                    cell_next  = '0;
                end else begin
                    drain_next = drain_reg + DRAIN_W'(1);
                end
            end
            ST_CLOSE: begin
                if (cell_reg == LAST_CELL) begin
                    state_next = ST_DONE;
                    cell_next  = '0;
                end else begin
                    cell_next = cell_reg + 5'd1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_reg != ST_IDLE);
        done     = (state_reg == ST_DONE);
        overflow = overflow_reg;
        bank     = bank_reg;
        rd_en    = (state_reg == ST_READ);
        rd_cell  = rd_en ? cell_reg : '0;
        rd_addr  = rd_en ? addr_reg : '0;
        dp_p     = dp_valid ? rd_p : '0;
        dp_v     = dp_valid ? rd_v : '0;
        wr_en    = res_write || close_write;
        wr_cell  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        if (close_write) begin
            wr_cell = cell_reg;
            wr_addr = cnt_val[ADDR_W-1:0];
            wr_data = NULL_PARTICLE;
        end else if (res_write) begin
            wr_cell = dp_cidx[4:0];
            wr_addr = cnt_val[ADDR_W-1:0];
            wr_data = dp_newp;
        end
    end

endmodule
